// File: rtl/freq_gen.sv
// freq_gen: programmable square-wave generator with boundary-synchronous reload.
// Optional per-load high time enabled by defining FREQ_GEN_DUTY_EN.
module freq_gen #(
  parameter int WIDTH = 16,
  parameter int DEFAULT_PERIOD = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] period,
`ifdef FREQ_GEN_DUTY_EN
  input  logic [WIDTH-1:0] duty,
`endif
  output logic             wave,
  output logic             period_start,
  output logic             busy,
  output logic             load_pending,
  output logic             cfg_err
);
  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d, act_p_q, act_p_d, pend_p_q, pend_p_d;
  logic [WIDTH-1:0] act_h, eff_p, eff_h;
  logic pend_q, pend_d, wave_q, wave_d, ps_q, ps_d, err_q, err_d;
  logic valid, bnd, direct, start;
  localparam logic [WIDTH-1:0] DEF_P = WIDTH'(DEFAULT_PERIOD);
  localparam logic [WIDTH-1:0] DEF_H = WIDTH'((DEFAULT_PERIOD + 1) / 2);
  assign bnd    = state_q == LOW && cnt_q == '0;
  assign direct = load && valid && (state_q == IDLE || bnd);
  assign eff_p  = direct ? period : (bnd && pend_q) ? pend_p_q : act_p_q;
`ifdef FREQ_GEN_DUTY_EN
  logic [WIDTH-1:0] act_h_q, act_h_d, pend_h_q, pend_h_d;
  assign valid = period >= WIDTH'(2) && duty != '0 && duty < period;
  assign act_h = act_h_q;
  assign eff_h = direct ? duty : (bnd && pend_q) ? pend_h_q : act_h_q;
  assign act_h_d  = (state_q == IDLE || bnd) ? eff_h : act_h_q;
  assign pend_h_d = (load && valid && busy && !bnd) ? duty : pend_h_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      act_h_q  <= DEF_H;
      pend_h_q <= '0;
    end else begin
      act_h_q  <= act_h_d;
      pend_h_q <= pend_h_d;
    end
`else
  function automatic logic [WIDTH-1:0] half(input logic [WIDTH-1:0] p);
    return WIDTH'(({1'b0, p} + 1'b1) >> 1);
  endfunction
  assign valid = period >= WIDTH'(2);
  assign act_h = half(act_p_q);
  assign eff_h = half(eff_p);
`endif
  assign start = en && (state_q == IDLE || bnd);
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wave_d   = wave_q;
    ps_d     = 1'b0;
    err_d    = load && !valid;
    act_p_d  = (state_q == IDLE || bnd) ? eff_p : act_p_q;
    pend_p_d = pend_p_q;
    pend_d   = bnd ? 1'b0 : pend_q;
    // Loads outside a boundary wait so the running period is never distorted.
    if (load && valid && busy && !bnd) begin
      pend_p_d = period;
      pend_d   = 1'b1;
    end
    if (start) begin
      state_d = HIGH;
      cnt_d   = eff_h - 1'b1;
      wave_d  = 1'b1;
      ps_d    = 1'b1;
    end else if (bnd) begin
      state_d = IDLE;
    end else if (state_q == HIGH && cnt_q == '0) begin
      state_d = LOW;
      cnt_d   = act_p_q - act_h - 1'b1;
      wave_d  = 1'b0;
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      act_p_q  <= DEF_P;
      pend_p_q <= '0;
      pend_q   <= 1'b0;
      wave_q   <= 1'b0;
      ps_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      act_p_q  <= act_p_d;
      pend_p_q <= pend_p_d;
      pend_q   <= pend_d;
      wave_q   <= wave_d;
      ps_q     <= ps_d;
      err_q    <= err_d;
    end
  assign wave         = wave_q;
  assign period_start = ps_q;
  assign busy         = state_q != IDLE;
  assign load_pending = pend_q;
  assign cfg_err      = err_q;
endmodule

// File: tb/tb_freq_gen.sv
// tb_freq_gen: randomized self-checking bench for freq_gen against a cycle-index model.
module tb_freq_gen;
  localparam int W = 16;
  localparam int DEF = 1000;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, load = 1'b0;
  logic [W-1:0] period = '0;
  logic wave, period_start, busy, load_pending, cfg_err;
  int total = 0, bad = 0, cur_p = DEF;

  freq_gen #(.WIDTH(W), .DEFAULT_PERIOD(DEF)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .period(period),
    .wave(wave), .period_start(period_start), .busy(busy),
    .load_pending(load_pending), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (busy && n < 3000) begin
      step;
      n++;
    end
    total++;
    if (busy) begin
      bad++;
      $display("FAIL wait_idle: busy=%0b required 0 within 3000 cycles", busy);
    end
  endtask

  // Ref: cycle k of a run at period p is high iff (k mod p) < ceil(p/2).
  task automatic run_check(input int p, input int n, input bit do_load);
    int h, stop;
    logic [3:0] exp_v;
    h = (p + 1) / 2;
    stop = ((n - 1) / p + 1) * p;
    wait_idle;
    if (do_load) begin
      load = 1'b1;
      period = W'(p);
      cur_p = p;
    end
    en = 1'b1;
    for (int k = 0; k < stop + 2; k++) begin
      step;
      load = 1'b0;
      exp_v = {k < stop && (k % p) < h, k < stop && (k % p) == 0, k < stop, 1'b0};
      total++;
      if ({wave, period_start, busy, load_pending} !== exp_v) begin
        bad++;
        if (bad < 20)
          $display("FAIL run p=%0d k=%0d: {wave,ps,busy,pend}=%b required %b", p, k,
                   {wave, period_start, busy, load_pending}, exp_v);
      end
      if (k == n - 1) en = 1'b0;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) step;
    total++;
    if ({wave, period_start, busy, load_pending, cfg_err} !== 5'b0) begin
      bad++;
      $display("FAIL reset: outputs=%b required 00000",
               {wave, period_start, busy, load_pending, cfg_err});
    end
    #2 rst_n = 1'b1;
    step;
    total++;
    if ({wave, busy} !== 2'b0) begin
      bad++;
      $display("FAIL reset_idle: {wave,busy}=%b required 00", {wave, busy});
    end
  endtask

  task automatic test_default;
    run_check(DEF, 2 * DEF, 1'b0);
  endtask

  task automatic test_patterns;
    run_check(7, 21, 1'b1);
    run_check(2, 6, 1'b1);
    run_check(10, 3, 1'b1);
    for (int i = 0; i < 8; i++) begin
      int p;
      p = int'($urandom_range(2, 40));
      run_check(p, int'($urandom_range(1, 3 * p)), 1'b1);
    end
  endtask

  task automatic test_pending;
    logic [2:0] exp_v;
    wait_idle;
    load = 1'b1;
    period = W'(10);
    en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step;
      load = (k == 3);
      if (k == 3) period = W'(20);
      exp_v[2] = k < 10 ? (k % 10) < 5 : ((k - 10) % 20) < 10;
      exp_v[1] = k < 10 ? k == 0 : ((k - 10) % 20) == 0;
      exp_v[0] = k >= 4 && k < 10;
      total++;
      if ({wave, period_start, load_pending} !== exp_v) begin
        bad++;
        $display("FAIL pending k=%0d: {wave,ps,pend}=%b required %b", k,
                 {wave, period_start, load_pending}, exp_v);
      end
      if (k == 49) en = 1'b0;
    end
    load = 1'b0;
    cur_p = 20;
  endtask

  task automatic test_boundary_load;
    logic [2:0] exp_v;
    wait_idle;
    load = 1'b1;
    period = W'(6);
    en = 1'b1;
    for (int k = 0; k < 18; k++) begin
      step;
      load = (k == 5);
      if (k == 5) period = W'(4);
      exp_v[2] = k < 6 ? k < 3 : ((k - 6) % 4) < 2;
      exp_v[1] = k < 6 ? k == 0 : ((k - 6) % 4) == 0;
      exp_v[0] = 1'b0;
      total++;
      if ({wave, period_start, load_pending} !== exp_v) begin
        bad++;
        $display("FAIL bnd_load k=%0d: {wave,ps,pend}=%b required %b", k,
                 {wave, period_start, load_pending}, exp_v);
      end
      if (k == 17) en = 1'b0;
    end
    load = 1'b0;
    cur_p = 4;
  endtask

  task automatic test_cfg_err;
    for (int i = 0; i < 2; i++) begin
      wait_idle;
      load = 1'b1;
      period = W'(i);
      step;
      load = 1'b0;
      total++;
      if (cfg_err !== 1'b1) begin
        bad++;
        $display("FAIL cfg_err_pulse p=%0d: cfg_err=%b required 1", i, cfg_err);
      end
      step;
      total++;
      if (cfg_err !== 1'b0) begin
        bad++;
        $display("FAIL cfg_err_width p=%0d: cfg_err=%b required 0", i, cfg_err);
      end
    end
    run_check(cur_p, 2 * cur_p, 1'b0);
  endtask

  task automatic test_async_reset;
    wait_idle;
    load = 1'b1;
    period = W'(10);
    en = 1'b1;
    step;
    load = 1'b0;
    step;
    load = 1'b1;
    period = W'(30);
    step;
    load = 1'b0;
    total++;
    if ({wave, load_pending} !== 2'b11) begin
      bad++;
      $display("FAIL arst_setup: {wave,pend}=%b required 11", {wave, load_pending});
    end
    #2 rst_n = 1'b0;
    en = 1'b0;
    #1;
    total++;
    if ({wave, period_start, busy, load_pending, cfg_err} !== 5'b0) begin
      bad++;
      $display("FAIL arst_clear: outputs=%b required 00000",
               {wave, period_start, busy, load_pending, cfg_err});
    end
    step;
    #2 rst_n = 1'b1;
    cur_p = DEF;
    run_check(DEF, DEF + 1, 1'b0);
  endtask

  initial begin
    test_reset;
    test_default;
    test_patterns;
    test_pending;
    test_boundary_load;
    test_cfg_err;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
